ring_step_sequencer: RTL and testbench

Step scheduler for the 5-position, 15-bit one-hot ring counter (active bits 14, 2, 5, 8, 11).
- Generates the counter's single-cycle enable pulses at a programmable period.
- Supports run, stop and single-step modes.
- Tracks ring position and completed laps, and ends a run automatically after a programmed lap count.
- Sits between the top-level control logic and the ring counter's en input; both blocks share clk and rst_n.

---
 rtl/ring_step_sequencer.sv | 110 +++++++++++
 tb/tb_ring_step_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ring_step_sequencer.sv
// Step scheduler for the 5-position one-hot ring counter: timed runs with a
// lap-count auto-stop, manual single steps, and position/lap tracking.
module ring_step_sequencer #(
  parameter int DIV_W   = 24,
  parameter int LAP_W   = 8,
  parameter int NUM_POS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  input  logic [DIV_W-1:0] period,
  input  logic [LAP_W-1:0] lap_target,
  output logic             ring_en,
  output logic [2:0]       pos,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [2:0]       POS_MAX = 3'(NUM_POS - 1);

  state_t           st;
  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] period_q;
  logic [LAP_W-1:0] target_q;

  logic             wrap;
  logic [2:0]       pos_nxt;
  logic [LAP_W-1:0] lap_inc;
  logic             tgt_hit;

  always_comb begin
    wrap    = (pos == POS_MAX);
    pos_nxt = wrap ? 3'd0 : pos + 3'd1;
    lap_inc = (&lap_cnt) ? lap_cnt : lap_cnt + LAP_W'(1);
    // compare one bit wider so lap_cnt+1 cannot alias to zero on overflow
    tgt_hit = wrap && (target_q != '0) &&
              ({1'b0, lap_cnt} + (LAP_W+1)'(1) == {1'b0, target_q});
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      divider  <= '0;
      period_q <= DIV_ONE;
      target_q <= '0;
      ring_en  <= 1'b0;
      pos      <= 3'd0;
      lap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ring_en <= 1'b0;
      done    <= 1'b0;
      case (st)
        IDLE: begin
          if (stop) begin
            st <= IDLE;
          end else if (start) begin
            st       <= RUN;
            busy     <= 1'b1;
            divider  <= '0;
            lap_cnt  <= '0;
            period_q <= (period == '0) ? DIV_ONE : period;
            target_q <= lap_target;
          end else if (step_req) begin
            ring_en <= 1'b1;
            pos     <= pos_nxt;
            if (wrap) lap_cnt <= lap_inc;
          end
        end
        RUN: begin
          if (stop) begin
            st      <= IDLE;
            busy    <= 1'b0;
            divider <= '0;
          end else if (divider == period_q - DIV_ONE) begin
            divider <= '0;
            ring_en <= 1'b1;
            pos     <= pos_nxt;
            if (wrap) lap_cnt <= lap_inc;
            if (tgt_hit) begin
              st   <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            divider <= divider + DIV_ONE;
          end
        end
        DONE: begin
          st <= IDLE;
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_step_sequencer.sv
// Directed bench for ring_step_sequencer: manual steps, timed runs, lap
// auto-stop, stop/start corner cases and mid-run reset.
module tb_ring_step_sequencer;

  localparam int DIV_W = 24;
  localparam int LAP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, step_req;
  logic [DIV_W-1:0] period;
  logic [LAP_W-1:0] lap_target;
  logic             ring_en, busy, done;
  logic [2:0]       pos;
  logic [LAP_W-1:0] lap_cnt;
  logic [1:0]       state;

  int n_run  = 0;
  int n_fail = 0;

  ring_step_sequencer #(.DIV_W(DIV_W), .LAP_W(LAP_W), .NUM_POS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_req(step_req),
    .period(period), .lap_target(lap_target), .ring_en(ring_en), .pos(pos),
    .lap_cnt(lap_cnt), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_ring_en"}, 32'(ring_en), 0);
    chk({tag, "_pos"}, 32'(pos), 0);
    chk({tag, "_lap"}, 32'(lap_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_req = 1'b0;
    period = '0; lap_target = '0;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // manual steps in IDLE
    for (int i = 0; i < 7; i++) begin
      step_req = 1'b1;
      tick();
      chk("step_en", 32'(ring_en), 1);
      chk("step_pos", 32'(pos), 32'((i + 1) % 5));
      chk("step_busy", 32'(busy), 0);
      step_req = 1'b0;
      tick();
      chk("step_gap", 32'(ring_en), 0);
    end
    chk("step_lap", 32'(lap_cnt), 1);

    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // period 4, two laps -> 10 pulses then done
    period = 4; lap_target = 2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("run4_busy", 32'(busy), 1);
    chk("run4_state", 32'(state), 1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("run4_en", 32'(ring_en), (k % 4 == 0) ? 1 : 0);
      chk("run4_done", 32'(done), (k == 40) ? 1 : 0);
    end
    chk("run4_pos", 32'(pos), 0);
    chk("run4_lap", 32'(lap_cnt), 2);
    chk("run4_st_done", 32'(state), 2);
    chk("run4_busy_end", 32'(busy), 0);
    tick();
    chk("run4_st_idle", 32'(state), 0);
    chk("run4_done_clr", 32'(done), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("run4_silent", 32'(ring_en), 0);
    end

    // period 0 treated as 1, run forever
    period = 0; lap_target = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("run1_first", 32'(ring_en), 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("run1_en", 32'(ring_en), 1);
      chk("run1_pos", 32'(pos), 32'(k % 5));
      chk("run1_lap", 32'(lap_cnt), 32'(k / 5));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_en", 32'(ring_en), 0);
    chk("stop_state", 32'(state), 0);
    chk("stop_pos", 32'(pos), 2);
    tick();
    chk("stop_pos_hold", 32'(pos), 2);
    chk("stop_idle_en", 32'(ring_en), 0);

    // period latched at start; step_req ignored in RUN
    period = 3; start = 1'b1;
    tick();
    start = 1'b0; period = 10;
    for (int k = 1; k <= 12; k++) begin
      step_req = (k == 1 || k == 2);
      tick();
      chk("run3_en", 32'(ring_en), (k % 3 == 0) ? 1 : 0);
    end
    step_req = 1'b0;
    chk("run3_pos", 32'(pos), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("run3_stop", 32'(state), 0);

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_state", 32'(state), 0);
    chk("ss_en", 32'(ring_en), 0);

    // start+step_req: run wins, no immediate pulse
    period = 1; lap_target = 0; start = 1'b1; step_req = 1'b1;
    tick();
    start = 1'b0; step_req = 1'b0;
    chk("sq_state", 32'(state), 1);
    chk("sq_en", 32'(ring_en), 0);
    chk("sq_pos", 32'(pos), 1);
    for (int k = 0; k < 27; k++) tick();
    chk("pre_rst_pos", 32'(pos), 3);
    chk("pre_rst_lap", 32'(lap_cnt), 5);

    // reset mid-run
    rst_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    period = 2; lap_target = 1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_gap", 32'(ring_en), 0);
    tick();
    chk("post_en", 32'(ring_en), 1);
    chk("post_pos", 32'(pos), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("post_stop", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
